// File: rtl/pc_kbd_pkg.sv
// Shared types and constants for the XT keyboard receiver.
// Optional timeout logic is enabled by the KBD_TIMEOUT_EN macro.
package pc_kbd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FULL  = 2'd2
  } kbd_state_e;

  localparam int KBD_DATA_BITS = 8;
  localparam logic [3:0] KBD_LAST_BIT = 4'(KBD_DATA_BITS - 1);

endpackage

// File: rtl/sync_falling_edge.sv
// Two-flop synchroniser plus a delay flop; flags a falling edge
// of an asynchronous pin in the clk domain.
module sync_falling_edge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic pin_i,
  output logic fall_o
);

  logic [2:0] sh_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) sh_q <= 3'b111;
    else       sh_q <= {sh_q[1:0], pin_i};
  end

  // sh_q[1] is the synchronised level, sh_q[2] its delayed copy
  assign fall_o = sh_q[2] & ~sh_q[1];

endmodule

// File: rtl/kbd_shift_receiver.sv
// XT keyboard frame deserialiser feeding the port-A tristate buffer.
// Define KBD_TIMEOUT_EN to build the mid-frame timeout and frame_err.
module kbd_shift_receiver
  import pc_kbd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       kbd_clk,
  input  logic       kbd_data,
  input  logic       clr,
  input  logic       rd_n,
  output logic [3:0] code_lo,
  output logic [3:0] code_hi,
  output logic       buf_g1_n,
  output logic       buf_g2_n,
  output logic       irq,
  output logic       kbd_clk_inhibit,
  output logic       frame_err
);

  kbd_state_e state_q, state_d;
  logic [7:0] sr_q, sr_d, code_q, code_d;
  logic [7:0] sr_shift;
  logic [3:0] cnt_q, cnt_d;
  logic       irq_q, irq_d;
  logic       inh_q, inh_d;
  logic       ferr_q, ferr_d;
  logic [1:0] dsync_q;
  logic       data_s;
  logic       fall;
  logic       tmo;
  logic       unused_sr0;

  sync_falling_edge u_clk_sync (
    .clk_i  (clk),
    .rst_i  (reset),
    .pin_i  (kbd_clk),
    .fall_o (fall)
  );

  always_ff @(posedge clk) begin
    if (reset) dsync_q <= 2'b11;
    else       dsync_q <= {dsync_q[0], kbd_data};
  end

  assign data_s     = dsync_q[1];
  assign sr_shift   = {data_s, sr_q[7:1]};
  assign unused_sr0 = sr_q[0];

`ifdef KBD_TIMEOUT_EN
  localparam int unsigned TW =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] tmo_q, tmo_d;

  assign tmo = (state_q == SHIFT) && !fall && (tmo_q == TMO_LAST);

  always_comb begin
    tmo_d = tmo_q + 1'b1;
    if (clr || state_q != SHIFT || fall || tmo) tmo_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) tmo_q <= '0;
    else       tmo_q <= tmo_d;
  end
`else
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT_CYCLES;
  assign tmo        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:  if (fall && data_s) state_d = SHIFT;
        SHIFT: begin
          if (fall && cnt_q == KBD_LAST_BIT) state_d = FULL;
          else if (tmo)                      state_d = IDLE;
        end
        FULL:    state_d = FULL;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    sr_d   = sr_q;
    code_d = code_q;
    cnt_d  = cnt_q;
    irq_d  = irq_q;
    inh_d  = inh_q;
    ferr_d = 1'b0;
    if (clr) begin
      sr_d   = 8'h00;
      code_d = 8'h00;
      cnt_d  = 4'd0;
      irq_d  = 1'b0;
      inh_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (fall && data_s) cnt_d = 4'd0;
        SHIFT: begin
          if (fall) begin
            sr_d  = sr_shift;
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == KBD_LAST_BIT) begin
              code_d = sr_shift;
              irq_d  = 1'b1;
              inh_d  = 1'b1;
            end
          end else if (tmo) begin
            sr_d   = 8'h00;
            cnt_d  = 4'd0;
            ferr_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q   <= 8'h00;
      code_q <= 8'h00;
      cnt_q  <= 4'd0;
      irq_q  <= 1'b0;
      inh_q  <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      sr_q   <= sr_d;
      code_q <= code_d;
      cnt_q  <= cnt_d;
      irq_q  <= irq_d;
      inh_q  <= inh_d;
      ferr_q <= ferr_d;
    end
  end

  assign code_lo         = code_q[3:0];
  assign code_hi         = code_q[7:4];
  assign buf_g1_n        = rd_n;
  assign buf_g2_n        = rd_n;
  assign irq             = irq_q;
  assign kbd_clk_inhibit = inh_q;
  assign frame_err       = ferr_q;

endmodule

// File: tb/tb_kbd_shift_receiver.sv
// Bench for kbd_shift_receiver: vector table, corner sequences,
// and random traffic against a frame-level reference model.
module tb_kbd_shift_receiver;

`ifdef KBD_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       kbd_clk = 1'b1;
  logic       kbd_data = 1'b1;
  logic       clr = 1'b0;
  logic       rd_n = 1'b1;
  logic [3:0] code_lo, code_hi;
  logic       buf_g1_n, buf_g2_n;
  logic       irq, kbd_clk_inhibit, frame_err;

  int errors = 0;
  int checks = 0;
  int ferr_seen = 0;

  kbd_shift_receiver #(.TIMEOUT_CYCLES(16)) dut (
    .clk             (clk),
    .reset           (reset),
    .kbd_clk         (kbd_clk),
    .kbd_data        (kbd_data),
    .clr             (clr),
    .rd_n            (rd_n),
    .code_lo         (code_lo),
    .code_hi         (code_hi),
    .buf_g1_n        (buf_g1_n),
    .buf_g2_n        (buf_g2_n),
    .irq             (irq),
    .kbd_clk_inhibit (kbd_clk_inhibit),
    .frame_err       (frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (!reset && frame_err) ferr_seen++;

  // Frame-level reference: a collected-bit queue and flags
  bit         m_busy, m_full, m_hold;
  bit         m_q[$];
  logic [7:0] m_code;
  bit         m_irq;
  int         m_ferr = 0;

  function automatic void mdl_clr();
    m_busy = 0;
    m_full = 0;
    m_q.delete();
    m_code = 8'h00;
    m_irq  = 0;
  endfunction

  function automatic void mdl_fall(bit d);
    if (m_hold || m_full) return;
    if (!m_busy) begin
      if (d) begin
        m_busy = 1;
        m_q.delete();
      end
      return;
    end
    m_q.push_back(d);
    if (m_q.size() == 8) begin
      for (int i = 0; i < 8; i++) m_code[i] = m_q[i];
      m_irq  = 1;
      m_full = 1;
      m_busy = 0;
    end
  endfunction

  function automatic void mdl_idle();
    if (TMO_EN && m_busy) begin
      m_busy = 0;
      m_q.delete();
      m_ferr++;
    end
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic send_bit(input bit b);
    kbd_data = b;
    tick(4);
    kbd_clk = 1'b0;
    tick(5);
    kbd_clk = 1'b1;
    tick(5);
    mdl_fall(b);
  endtask

  task automatic send_frame(input logic [7:0] v);
    send_bit(1'b1);
    for (int i = 0; i < 8; i++) send_bit(v[i]);
  endtask

  task automatic clr_pulse();
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    mdl_clr();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    mdl_clr();
  endtask

  task automatic check_model(input string nm);
    check({nm, ".code"}, {code_hi, code_lo}, m_code);
    check({nm, ".irq"}, irq, m_irq);
    check({nm, ".inh"}, kbd_clk_inhibit, m_irq);
  endtask

  typedef struct {
    bit         pre_clr;
    bit         junk;
    logic [7:0] tx;
    logic [7:0] exp_code;
    bit         exp_irq;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int first, cnt;
    vecs[0] = '{1'b0, 1'b0, 8'h9C, 8'h1E, 1'b1};
    vecs[1] = '{1'b1, 1'b1, 8'h55, 8'h55, 1'b1};
    vecs[2] = '{1'b1, 1'b0, 8'h00, 8'h00, 1'b1};
    vecs[3] = '{1'b1, 1'b0, 8'hFF, 8'hFF, 1'b1};
    vecs[4] = '{1'b0, 1'b1, 8'h12, 8'hFF, 1'b1};
    mdl_clr();
    m_hold = 0;

    tick(3);
    reset = 1'b0;
    tick(1);
    check("rst.code_lo", code_lo, 4'h0);
    check("rst.code_hi", code_hi, 4'h0);
    check("rst.irq", irq, 1'b0);
    check("rst.inh", kbd_clk_inhibit, 1'b0);
    check("rst.ferr", frame_err, 1'b0);

    // 0x1E frame with an exact look at irq latency on the 9th edge
    send_bit(1'b1);
    for (int i = 0; i < 7; i++) send_bit(bit'((8'h1E >> i) & 1));
    kbd_data = 1'b0;
    tick(4);
    kbd_clk = 1'b0;
    tick(2);
    check("lat.irq_early", irq, 1'b0);
    tick(1);
    check("lat.irq", irq, 1'b1);
    check("lat.inh", kbd_clk_inhibit, 1'b1);
    check("lat.code_hi", code_hi, 4'h1);
    check("lat.code_lo", code_lo, 4'hE);
    tick(2);
    kbd_clk = 1'b1;
    tick(5);
    mdl_fall(1'b0);

    for (int v = 0; v < 5; v++) begin
      if (vecs[v].pre_clr) begin
        clr_pulse();
        check($sformatf("v%0d.clr_irq", v), irq, 1'b0);
        check($sformatf("v%0d.clr_inh", v), kbd_clk_inhibit, 1'b0);
        check($sformatf("v%0d.clr_code", v), {code_hi, code_lo}, 8'h00);
      end
      if (vecs[v].junk) send_bit(1'b0);
      send_frame(vecs[v].tx);
      check($sformatf("v%0d.code", v), {code_hi, code_lo},
            vecs[v].exp_code);
      check($sformatf("v%0d.irq", v), irq, vecs[v].exp_irq);
    end

    // clr held high: start bits ignored
    clr = 1'b1;
    mdl_clr();
    m_hold = 1;
    send_frame(8'h33);
    check("hold.code", {code_hi, code_lo}, 8'h00);
    check("hold.irq", irq, 1'b0);
    clr = 1'b0;
    m_hold = 0;
    tick(1);

    // clr then reset mid-frame
    send_bit(1'b1);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    clr_pulse();
    send_frame(8'h01);
    check("midclr.code", {code_hi, code_lo}, 8'h01);
    check("midclr.irq", irq, 1'b1);
    clr_pulse();
    send_bit(1'b1);
    for (int i = 0; i < 4; i++) send_bit(1'b0);
    do_reset();
    check("midrst.code", {code_hi, code_lo}, 8'h00);
    check("midrst.irq", irq, 1'b0);
    send_frame(8'h01);
    check("midrst.frame", {code_hi, code_lo}, 8'h01);

    // partial frame then long idle
    clr_pulse();
    send_bit(1'b1);
    for (int i = 0; i < 3; i++) send_bit(bit'((8'hAA >> i) & 1));
    first = -1;
    cnt = 0;
    for (int i = 1; i <= 40; i++) begin
      tick(1);
      if (frame_err) begin
        cnt++;
        if (first < 0) first = i;
      end
    end
    mdl_idle();
`ifdef KBD_TIMEOUT_EN
    check("tmo.pulses", cnt, 1);
    check("tmo.pos", first, 9);
    check("tmo.irq", irq, 1'b0);
    send_frame(8'hAA);
`else
    check("tmo.pulses", cnt, 0);
    for (int i = 3; i < 8; i++) send_bit(bit'((8'hAA >> i) & 1));
`endif
    check("tmo.code", {code_hi, code_lo}, 8'hAA);
    check("tmo.irq_done", irq, 1'b1);

    // buffer enables follow rd_n combinationally
    rd_n = 1'b0;
    #1;
    check("rd.g1_lo", buf_g1_n, 1'b0);
    check("rd.g2_lo", buf_g2_n, 1'b0);
    check("rd.code", {code_hi, code_lo}, 8'hAA);
    rd_n = 1'b1;
    #1;
    check("rd.g1_hi", buf_g1_n, 1'b1);
    check("rd.g2_hi", buf_g2_n, 1'b1);

    clr_pulse();
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 4))
        0: send_frame(8'($urandom));
        1: send_bit(1'b0);
        2: clr_pulse();
        3: send_bit(1'($urandom));
        default: begin
          tick(30);
          mdl_idle();
        end
      endcase
      check_model($sformatf("rnd%0d", n));
    end

    tick(2);
    check("ferr.count", ferr_seen, m_ferr);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
